// File: rtl/dm_store_buffer.sv
// Word-granular store buffer sitting in front of the data memory write port.
// Stores are queued in a circular FIFO and drained one per cycle whenever the
// DM port is free. Loads see the youngest queued copy of their word so that
// program order is preserved while stores are still in flight.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [31:0]              st_pc,
  output logic                     st_ready,
  input  logic [31:0]              ld_addr,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data,
  input  logic                     dm_busy,
  output logic                     dm_we,
  output logic [31:0]              dm_addr,
  output logic [31:0]              dm_wdata,
  output logic [31:0]              dm_pc,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push;
  logic             drain;
  logic [DEPTH-1:0] match;
  logic [PTR_W-1:0] fwd_idx;

  // Only the word index takes part in matching; the rest of the load address is
  // intentionally ignored.
  logic unused_ld_bits;
  assign unused_ld_bits = ^{ld_addr[31:IDX_W+2], ld_addr[1:0]};

  assign empty    = (count_q == '0);
  assign st_ready = (count_q != CNT_W'(DEPTH));
  assign count    = count_q;
  assign push     = st_valid && st_ready;
  assign drain    = dm_we;

  // Per-entry word-index comparators against the load in MEM
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_q[gi] &&
                         (addr_q[gi][IDX_W+1:2] == ld_addr[IDX_W+1:2]);
    end
  endgenerate

  // Drain port: present the head entry, write whenever the port is not claimed
  always_comb begin
    dm_we    = !empty && !dm_busy;
    dm_addr  = '0;
    dm_wdata = '0;
    dm_pc    = '0;
    if (!empty) begin
      dm_addr  = addr_q[head_q];
      dm_wdata = data_q[head_q];
      dm_pc    = pc_q[head_q];
    end
  end

  // Forwarding: walk oldest to youngest so the youngest match is assigned last
  always_comb begin
    fwd_hit  = |match;
    fwd_data = '0;
    fwd_idx  = tail_q;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      fwd_idx = tail_q - PTR_W'(k + 1);
      if (match[fwd_idx]) begin
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  // Next-state: pop head on drain, append at tail on accepted push
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push) begin
      addr_d[tail_q]  = st_addr;
      data_d[tail_q]  = st_data;
      pc_d[tail_q]    = st_pc;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    case ({push, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards queued entries without writing them to DM
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '{default: '0};
      data_q  <= '{default: '0};
      pc_q    <= '{default: '0};
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: a table of hand-derived cycles, a few
// directed multi-cycle sequences, then random traffic against a queue model.
module tb_dm_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr, st_data, st_pc;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        dm_busy;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_pc;
  logic        empty;
  logic [2:0]  count;

  dm_store_buffer #(.DEPTH(DEPTH), .IDX_W(10)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
    .st_ready(st_ready), .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .dm_busy(dm_busy), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_pc(dm_pc), .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are applied 1 time unit after a posedge; outputs are sampled 4 later.
  task automatic settle();
    #4;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [31:0] sp, input logic [31:0] la, input logic busy);
    st_valid = sv; st_addr = sa; st_data = sd; st_pc = sp; ld_addr = la; dm_busy = busy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 1'b1);
    next_edge();
    next_edge();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        sv;
    logic [31:0] sa, sd, la;
    logic        busy;
    logic        e_rdy, e_hit;
    logic [31:0] e_fd;
    logic        e_we;
    logic [31:0] e_da, e_dw;
    logic [2:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(logic sv, logic [31:0] sa, logic [31:0] sd, logic [31:0] la,
                              logic busy, logic e_rdy, logic e_hit, logic [31:0] e_fd,
                              logic e_we, logic [31:0] e_da, logic [31:0] e_dw, logic [2:0] e_cnt);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.la = la; v.busy = busy;
    v.e_rdy = e_rdy; v.e_hit = e_hit; v.e_fd = e_fd; v.e_we = e_we;
    v.e_da = e_da; v.e_dw = e_dw; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t tbl [15];

  // Reference model: program-ordered queue of pending stores plus two DM images
  typedef struct { logic [31:0] addr, data, pc; } ent_t;
  ent_t        mq [$];
  logic [31:0] model_mem [1024];
  logic [31:0] dut_mem   [1024];

  initial begin
    reset = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      model_mem[i] = '0;
      dut_mem[i]   = '0;
    end

    // Cycle table:      sv  st_addr  st_data        ld_addr     busy rdy hit fwd_data      we  dm_addr dm_wdata     cnt
    tbl[0]  = mk(1, 32'h20, 32'h11111111, 32'h23,   1, 1, 0, 32'h0,        0, 32'h0,  32'h0,        0);
    tbl[1]  = mk(1, 32'h20, 32'h22222222, 32'h23,   1, 1, 1, 32'h11111111, 0, 32'h20, 32'h11111111, 1);
    tbl[2]  = mk(0, 32'h0,  32'h0,        32'h23,   1, 1, 1, 32'h22222222, 0, 32'h20, 32'h11111111, 2);
    tbl[3]  = mk(0, 32'h0,  32'h0,        32'h1020, 1, 1, 1, 32'h22222222, 0, 32'h20, 32'h11111111, 2);
    tbl[4]  = mk(0, 32'h0,  32'h0,        32'h24,   1, 1, 0, 32'h0,        0, 32'h20, 32'h11111111, 2);
    tbl[5]  = mk(1, 32'h40, 32'h33333333, 32'h40,   1, 1, 0, 32'h0,        0, 32'h20, 32'h11111111, 2);
    tbl[6]  = mk(1, 32'h44, 32'h44444444, 32'h40,   1, 1, 1, 32'h33333333, 0, 32'h20, 32'h11111111, 3);
    tbl[7]  = mk(1, 32'h48, 32'h55555555, 32'h20,   1, 0, 1, 32'h22222222, 0, 32'h20, 32'h11111111, 4);
    tbl[8]  = mk(0, 32'h0,  32'h0,        32'h48,   1, 0, 0, 32'h0,        0, 32'h20, 32'h11111111, 4);
    tbl[9]  = mk(1, 32'h48, 32'h55555555, 32'h20,   0, 0, 1, 32'h22222222, 1, 32'h20, 32'h11111111, 4);
    tbl[10] = mk(1, 32'h48, 32'h55555555, 32'h20,   0, 1, 1, 32'h22222222, 1, 32'h20, 32'h22222222, 3);
    tbl[11] = mk(0, 32'h0,  32'h0,        32'h48,   0, 1, 1, 32'h55555555, 1, 32'h40, 32'h33333333, 3);
    tbl[12] = mk(0, 32'h0,  32'h0,        32'h40,   0, 1, 0, 32'h0,        1, 32'h44, 32'h44444444, 2);
    tbl[13] = mk(0, 32'h0,  32'h0,        32'h1048, 0, 1, 1, 32'h55555555, 1, 32'h48, 32'h55555555, 1);
    tbl[14] = mk(0, 32'h0,  32'h0,        32'h0,    0, 1, 0, 32'h0,        0, 32'h0,  32'h0,        0);

    // ---- Reset then idle ----
    next_edge();
    next_edge();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("idle_empty", 32'(empty), 32'd1);
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_ready", 32'(st_ready), 32'd1);
      chk("idle_we", 32'(dm_we), 32'd0);
      chk("idle_hit", 32'(fwd_hit), 32'd0);
      chk("idle_fwd_data", fwd_data, 32'd0);
      chk("idle_dm_addr", dm_addr, 32'd0);
      next_edge();
    end
    $display("idle: 5 cycles checked");

    // ---- Single store, drain on the next cycle ----
    drive(1'b1, 32'h10, 32'hDEADBEEF, 32'h3000, 32'h0, 1'b0);
    settle();
    chk("single_we_same_cycle", 32'(dm_we), 32'd0);
    next_edge();
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    settle();
    chk("single_we", 32'(dm_we), 32'd1);
    chk("single_addr", dm_addr, 32'h10);
    chk("single_data", dm_wdata, 32'hDEADBEEF);
    chk("single_pc", dm_pc, 32'h3000);
    next_edge();
    settle();
    chk("single_empty_after", 32'(empty), 32'd1);
    chk("single_we_after", 32'(dm_we), 32'd0);
    next_edge();
    $display("single store: 0x00000010 <= deadbeef drained");

    // ---- Fill under dm_busy, refuse fifth, then drain in order ----
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 32'h4000 + 32'(i * 4), 32'h0, 1'b1);
      next_edge();
    end
    drive(1'b1, 32'h10, 32'hBAD0BAD0, 32'h4010, 32'h10, 1'b1);
    settle();
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(st_ready), 32'd0);
    chk("full_we_busy", 32'(dm_we), 32'd0);
    next_edge();
    settle();
    chk("fifth_refused_count", 32'(count), 32'd4);
    chk("fifth_not_forwarded", 32'(fwd_hit), 32'd0);
    next_edge();
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("drain_we", 32'(dm_we), 32'd1);
      chk("drain_addr", dm_addr, 32'(i * 4));
      chk("drain_data", dm_wdata, 32'hA000_0000 + 32'(i));
      chk("drain_pc", dm_pc, 32'h4000 + 32'(i * 4));
      chk("drain_ready", 32'(st_ready), (i == 0) ? 32'd0 : 32'd1);
      $display("drain %0d: addr %h data %h", i, dm_addr, dm_wdata);
      next_edge();
    end
    settle();
    chk("drain_done_empty", 32'(empty), 32'd1);
    next_edge();

    // ---- Table: forwarding, full buffer with drain, steady accept/drain ----
    do_reset();
    for (int r = 0; r < 15; r++) begin
      drive(tbl[r].sv, tbl[r].sa, tbl[r].sd, 32'h5000 + 32'(r * 4), tbl[r].la, tbl[r].busy);
      settle();
      chk($sformatf("vec%0d_ready", r), 32'(st_ready), 32'(tbl[r].e_rdy));
      chk($sformatf("vec%0d_hit", r), 32'(fwd_hit), 32'(tbl[r].e_hit));
      chk($sformatf("vec%0d_fwd_data", r), fwd_data, tbl[r].e_fd);
      chk($sformatf("vec%0d_we", r), 32'(dm_we), 32'(tbl[r].e_we));
      chk($sformatf("vec%0d_dm_addr", r), dm_addr, tbl[r].e_da);
      chk($sformatf("vec%0d_dm_wdata", r), dm_wdata, tbl[r].e_dw);
      chk($sformatf("vec%0d_count", r), 32'(count), 32'(tbl[r].e_cnt));
      $display("vec %0d: st %b %h ld %h busy %b -> hit %b fwd %h we %b cnt %0d",
               r, tbl[r].sv, tbl[r].sa, tbl[r].la, tbl[r].busy, fwd_hit, fwd_data, dm_we, count);
      next_edge();
    end

    // ---- Reset with 3 entries queued: nothing reaches DM ----
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 32'h7000_0000 + 32'(i), 32'h6000, 32'h0, 1'b1);
      next_edge();
    end
    drive(1'b0, 0, 0, 0, 0, 1'b1);
    settle();
    chk("pre_reset_count", 32'(count), 32'd3);
    reset = 1'b1;
    next_edge();
    reset = 1'b0;
    drive(1'b0, 0, 0, 0, 32'h100, 1'b0);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("post_reset_we", 32'(dm_we), 32'd0);
      chk("post_reset_count", 32'(count), 32'd0);
      chk("post_reset_empty", 32'(empty), 32'd1);
      chk("post_reset_hit", 32'(fwd_hit), 32'd0);
      next_edge();
    end
    $display("reset with 3 queued: discarded");

    // ---- Random traffic against the queue model ----
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        rst_now, sv, busy, e_rdy, e_we, e_hit;
      logic [31:0] sa, la, e_fd;
      ent_t        e;
      rst_now = ($urandom_range(0, 199) == 0);
      sv      = ($urandom_range(0, 99) < 60);
      busy    = rst_now ? 1'b1 : ($urandom_range(0, 99) < 35);
      sa      = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      la      = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      reset   = rst_now;
      drive(sv, sa, $urandom, $urandom, la, busy);

      e_rdy = (mq.size() != DEPTH);
      e_we  = (mq.size() != 0) && !busy;
      e_hit = 1'b0;
      e_fd  = '0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].addr[11:2] == la[11:2]) begin
          e_hit = 1'b1;
          e_fd  = mq[i].data;
          break;
        end
      end

      settle();
      chk("rnd_ready", 32'(st_ready), 32'(e_rdy));
      chk("rnd_count", 32'(count), 32'(mq.size()));
      chk("rnd_empty", 32'(empty), 32'(mq.size() == 0));
      chk("rnd_we", 32'(dm_we), 32'(e_we));
      chk("rnd_dm_addr", dm_addr, (mq.size() != 0) ? mq[0].addr : 32'h0);
      chk("rnd_dm_wdata", dm_wdata, (mq.size() != 0) ? mq[0].data : 32'h0);
      chk("rnd_dm_pc", dm_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
      chk("rnd_hit", 32'(fwd_hit), 32'(e_hit));
      chk("rnd_fwd_data", fwd_data, e_fd);

      if (dm_we && !rst_now) dut_mem[dm_addr[11:2]] = dm_wdata;
      if (rst_now) begin
        mq.delete();
      end else begin
        if (e_we) begin
          model_mem[mq[0].addr[11:2]] = mq[0].data;
          void'(mq.pop_front());
        end
        if (sv && e_rdy) begin
          e.addr = st_addr; e.data = st_data; e.pc = st_pc;
          mq.push_back(e);
        end
      end
      next_edge();
    end
    reset = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 1'b0);

    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 1024; i++) if (dut_mem[i] !== model_mem[i]) bad++;
      chk("rnd_dm_image_mismatches", 32'(bad), 32'd0);
    end
    $display("random: 3000 cycles");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
